// File: rtl/if_fetch_unit_if.sv
// Bundles the fetch stage's memory handshake, IF/ID output and redirect/stall controls.
// With IF_MISALIGN_TRAP_EN defined the bundle also carries the misalign flag.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign;

  modport master (
    output imem_req, imem_addr, if_instr, if_pc, if_valid, misalign,
    input  imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, if_instr, if_pc, if_valid, misalign,
    output imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
`else
  modport master (
    output imem_req, imem_addr, if_instr, if_pc, if_valid,
    input  imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, if_instr, if_pc, if_valid,
    output imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
`endif
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem, buffers one instruction under stall.
// Optional IF_MISALIGN_TRAP_EN adds a one-cycle misalign flag on unaligned redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input logic          clock,
  input logic          reset,
  if_fetch_unit_if.master bus
);
  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  // FETCH: skid buffer empty, request outstanding. FULL: buffer holds one instruction.
  typedef enum logic {FETCH = 1'b0, FULL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        fetch_done;

  assign fetch_done    = (state_q == FETCH) && bus.imem_ready;
  assign bus.imem_req  = (state_q == FETCH) && !reset;
  assign bus.imem_addr = pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_valid  = if_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;

    if (bus.redirect) begin
      // A fetch completing alongside the redirect is dropped on purpose.
      pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
      state_d    = FETCH;
      if_instr_d = '0;
      if_pc_d    = '0;
      if_valid_d = 1'b0;
    end else if (bus.stall) begin
      if (fetch_done) begin
        buf_instr_d = bus.imem_rdata;
        buf_pc_d    = pc_q;
        pc_d        = pc_q + PC_INC;
        state_d     = FULL;
      end
    end else if (state_q == FULL) begin
      if_instr_d = buf_instr_q;
      if_pc_d    = buf_pc_q;
      if_valid_d = 1'b1;
      state_d    = FETCH;
    end else if (fetch_done) begin
      if_instr_d = bus.imem_rdata;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + PC_INC;
    end else begin
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  // NOTE: buffer payload needs no reset; it is only read when state_q == FULL.
  always_ff @(posedge clock) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clock) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  end

  assign bus.misalign = misalign_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed test-plan steps then randomized traffic
// checked against a queue-based reference model of the fetch stage.
module tb_if_fetch_unit;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } pkt_t;

  logic clock;
  logic reset;
  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, at most one held instruction, registered outputs.
  logic [31:0] m_pc;
  pkt_t        pend[$];
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] stream_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the request side, advance
  // the model at the rising edge and check the registered outputs just after it.
  task automatic step(input logic rst, input logic rdy, input logic stl,
                      input logic rdr, input logic [31:0] rpc);
    logic [31:0] data;
    logic        emitted;
    pkt_t        p;
    data = rdy ? mem_word(m_pc) : $urandom;
    reset           = rst;
    bus.imem_ready  = rdy;
    bus.imem_rdata  = data;
    bus.stall       = stl;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    #1;
    check("imem_req", 32'(bus.imem_req), 32'(!rst && pend.size() == 0));
    if (!rst && pend.size() == 0) check("imem_addr", bus.imem_addr, m_pc);

    emitted = 1'b0;
    if (rst) begin
      m_pc = 32'h0; pend.delete();
      m_instr = '0; m_opc = '0; m_valid = 1'b0; m_mis = 1'b0;
      stream_next = 32'h0;
    end else if (rdr) begin
      m_pc = {rpc[31:2], 2'b00}; pend.delete();
      m_instr = '0; m_opc = '0; m_valid = 1'b0;
      m_mis = (rpc[1:0] != 2'b00);
      stream_next = m_pc;
    end else begin
      m_mis = 1'b0;
      if (stl) begin
        if (pend.size() == 0 && rdy) begin
          pend.push_back({data, m_pc});
          m_pc = m_pc + 32'd4;
        end
      end else if (pend.size() != 0) begin
        p = pend.pop_front();
        m_instr = p.instr; m_opc = p.pc; m_valid = 1'b1; emitted = 1'b1;
      end else if (rdy) begin
        m_instr = data; m_opc = m_pc; m_valid = 1'b1; emitted = 1'b1;
        m_pc = m_pc + 32'd4;
      end else begin
        m_instr = '0; m_valid = 1'b0;
      end
    end

    @(posedge clock);
    #1;
    check("if_valid", 32'(bus.if_valid), 32'(m_valid));
    check("if_instr", bus.if_instr, m_instr);
    check("if_pc", bus.if_pc, m_opc);
`ifdef IF_MISALIGN_TRAP_EN
    check("misalign", 32'(bus.misalign), 32'(m_mis));
`endif
    // Emitted PCs must form an unbroken +4 stream between redirects: nothing lost or repeated.
    if (emitted) begin
      check("stream_pc", bus.if_pc, stream_next);
      stream_next = stream_next + 32'd4;
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.stall = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    m_pc = '0; m_instr = '0; m_opc = '0; m_valid = 1'b0; m_mis = 1'b0; stream_next = '0;
    @(negedge clock);

    // Reset, including memory claiming ready while reset is high.
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("rst_valid", 32'(bus.if_valid), 32'h0);
    check("rst_pc", bus.if_pc, 32'h0);
    check("rst_instr", bus.if_instr, 32'h0);

    // Continuous fetch, then a 3-cycle stall and release.
    step(0, 1, 0, 0, 0); check("seq_pc0", bus.if_pc, 32'h0);
    step(0, 1, 0, 0, 0); check("seq_pc4", bus.if_pc, 32'h4);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0); check("stall_hold_pc", bus.if_pc, 32'h4);
    step(0, 1, 0, 0, 0); check("drain_pc8", bus.if_pc, 32'h8);
    step(0, 1, 0, 0, 0); check("after_drain_pc12", bus.if_pc, 32'hC);

    // Redirect while FULL (buffer pc=8) and stalled: buffered pc=8 must vanish.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'h0000_0100);
    check("redir_valid", 32'(bus.if_valid), 32'h0);
    check("redir_addr", bus.imem_addr, 32'h100);
    step(0, 1, 0, 0, 0); check("redir_pc", bus.if_pc, 32'h100);

    // imem_ready low for two cycles at 0x20.
    step(0, 0, 0, 1, 32'h20);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("bubble_valid", 32'(bus.if_valid), 32'h0);
    check("bubble_instr", bus.if_instr, 32'h0);
    step(0, 1, 0, 0, 0); check("after_bubble_pc", bus.if_pc, 32'h20);

    // PC wrap-around.
    step(0, 1, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0); check("wrap_pc0", bus.if_pc, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0); check("wrap_pc1", bus.if_pc, 32'h0);
    step(0, 1, 0, 0, 0); check("wrap_pc2", bus.if_pc, 32'h4);

    // Unaligned redirect target is aligned down.
    step(0, 1, 0, 1, 32'h0000_0102);
    check("misalign_addr", bus.imem_addr, 32'h100);
`ifdef IF_MISALIGN_TRAP_EN
    check("misalign_hi", 32'(bus.misalign), 32'h1);
`endif
    step(0, 1, 0, 0, 0);
    check("misalign_pc", bus.if_pc, 32'h100);
`ifdef IF_MISALIGN_TRAP_EN
    check("misalign_lo", 32'(bus.misalign), 32'h0);
`endif

    // Reset with a full buffer behaves like reset from idle.
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check("rst_full_valid", 32'(bus.if_valid), 32'h0);
    step(0, 1, 0, 0, 0); check("rst_full_pc", bus.if_pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch (IF) stage that produces the instruction/PC pair consumed by the IF/ID pipeline register; it is the writer end of that interface.
- Owns the program counter and issues single-cycle-handshake requests to instruction memory.
- Holds one prefetched instruction in a skid buffer while ID stalls; takes branch/jump redirects from later stages.
- Presents registered if_instr/if_pc/if_valid to the IF/ID register every cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clock  in  1  stage clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- imem_req  out  1  fetch request, combinational from state.
- imem_addr  out  32  fetch address, equal to current pc.
- imem_ready  in  1  memory returns imem_rdata this cycle for the current request.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- stall  in  1  ID cannot accept; outputs must hold.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new fetch target.
- if_instr  out  32  instruction to IF/ID (drives IF_IN).
- if_pc  out  32  PC of if_instr (drives IF_PC).
- if_valid  out  1  if_instr is a real instruction; 0 = bubble (if_instr=0, a MIPS NOP).

Behaviour:
- Reset (clock edge with reset=1): pc=RESET_PC, state=FETCH, buffer empty, if_instr=0, if_pc=0, if_valid=0. In the cycle reset is high, imem_req=0.
- Two states:
  - FETCH: buffer empty; imem_req=1, imem_addr=pc.
  - FULL: buffer holds one instruction and its PC; imem_req=0.
- A fetch completes in a cycle when state=FETCH and imem_ready=1. The handshake is single-cycle; memory may hold imem_ready low for any number of cycles.
- Priority per edge, highest first: reset, redirect, stall, normal.
- Redirect (reset=0, redirect=1):
  - pc <= {redirect_pc[31:2],2'b00}; buffer emptied; state <= FETCH.
  - if_valid <= 0, if_instr <= 0, if_pc <= 0.
  - Any completing fetch in that cycle is discarded. Applies regardless of stall.
- Stall (stall=1, no redirect):
  - if_instr/if_pc/if_valid hold.
  - If state=FETCH and imem_ready=1: buffer <= {imem_rdata, pc}, pc <= pc+PC_STEP, state <= FULL.
  - If state=FULL: nothing changes.
- Normal (stall=0, no redirect):
  - state=FULL: outputs <= buffer contents, if_valid <= 1, state <= FETCH. No fetch is issued this cycle because imem_req=0.
  - state=FETCH, imem_ready=1: if_instr <= imem_rdata, if_pc <= pc, if_valid <= 1, pc <= pc+PC_STEP.
  - state=FETCH, imem_ready=0: bubble (if_valid <= 0, if_instr <= 0); if_pc holds.
- Latency: instruction appears on outputs one edge after its ready cycle. Sustained throughput is 1 instruction/cycle when imem_ready=1 continuously and stall=0.
- Arithmetic: pc+PC_STEP is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- No instruction is lost or duplicated across any stall/redirect sequence.
- Reset asserted mid-stall or with a full buffer discards everything; it behaves identically to reset from idle.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Adds port misalign (out, 1).
  - On an edge where redirect=1 and redirect_pc[1:0]!=0, misalign <= 1 for exactly one cycle; otherwise misalign <= 0. Reset value is 0.
  - pc is still aligned as in Behaviour.
- Undefined: port absent; low bits of redirect_pc are silently cleared.

Test Plan:
- Reset then imem_ready=1 constantly, stall=0, imem_rdata = address-derived words → imem_addr 0,4,8,12; outputs (pc,valid) = (0,1),(4,1),(8,1) on consecutive cycles, starting one edge after first ready.
- stall=1 for 3 cycles while imem_ready=1, outputs showing pc=4 → outputs hold pc=4; pc=8 captured in buffer; imem_req=0 for remaining stall cycles; after release, outputs pc=8, then pc=12, with no gap beyond the FULL drain cycle.
- State FULL with buffer pc=8, redirect=1 with redirect_pc=32'h0000_0100 while stall=1 → next cycle if_valid=0 and imem_addr=32'h100; then outputs pc=0x100; pc=8 is never emitted.
- imem_ready low for 2 cycles at pc=0x20 → two bubbles (if_valid=0, if_instr=0), then instruction at 0x20 with if_valid=1.
- redirect_pc=32'hFFFF_FFFC, continuous ready → if_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
- With IF_MISALIGN_TRAP_EN: redirect_pc=32'h0000_0102 → misalign high for exactly 1 cycle; fetch address 32'h100.
